// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: command encodings, FSM states
// and the fixed datapath dimensions.
package alu_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_NREG  = 4;
  localparam int ALU_AW    = 2;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_NAND = 2'b10,
    OP_CMP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: modulo-2^WIDTH add (sel=0) or bitwise NAND (sel=1),
// with operand-equality and signed-overflow indications.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sel,
  output logic [WIDTH-1:0] RES,
  output logic             eq,
  output logic             ovf
);

  always_comb begin
    RES = sel ? ~(A & B) : A + B;
    eq  = (A == B);
    // Overflow only has meaning for the add path.
    ovf = !sel && (A[WIDTH-1] == B[WIDTH-1]) && (RES[WIDTH-1] != A[WIDTH-1]);
  end

endmodule

// File: rtl/alu_seq.sv
// Four-state command sequencer around the ALU with an inline register file,
// a registered result, sticky equality/overflow flags and a debug read port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREG  = ALU_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [ALU_AW-1:0] op_rd,
  input  logic [ALU_AW-1:0] op_ra,
  input  logic [ALU_AW-1:0] op_rb,
  input  logic [WIDTH-1:0]  op_imm,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              flag_eq,
  output logic              flag_ovf,
  input  logic [ALU_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  state_e              state_q, state_d;
  op_e                 code_q;
  logic [ALU_AW-1:0]   rd_q, ra_q, rb_q;
  logic [WIDTH-1:0]    imm_q;
  logic [WIDTH-1:0]    rf_q [NREG];
  logic [WIDTH-1:0]    a_q, b_q, res_q, result_q;
  logic                eq_q, ovf_q, flag_eq_q, flag_ovf_q, done_q;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_eq, alu_ovf;
  logic                accept;

  alu #(.WIDTH(WIDTH)) u_alu (
    .A   (a_q),
    .B   (b_q),
    .sel (code_q == OP_NAND),
    .RES (alu_res),
    .eq  (alu_eq),
    .ovf (alu_ovf)
  );

  always_comb begin
    state_d  = state_q;
    op_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_d = S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = op_valid && op_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= OP_LOAD;
      rd_q   <= '0;
      ra_q   <= '0;
      rb_q   <= '0;
      imm_q  <= '0;
    end else if (accept) begin
      code_q <= op_e'(op_code);
      rd_q   <= op_rd;
      ra_q   <= op_ra;
      rb_q   <= op_rb;
      imm_q  <= op_imm;
    end
  end

  // Operands are captured in READ, so a WB write to an aliased register
  // cannot disturb the command that produced it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      eq_q       <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      flag_eq_q  <= 1'b0;
      flag_ovf_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_READ: begin
          a_q <= rf_q[ra_q];
          b_q <= rf_q[rb_q];
        end
        S_EXEC: begin
          res_q <= alu_res;
          eq_q  <= alu_eq;
          ovf_q <= alu_ovf;
        end
        S_WB: begin
          done_q <= 1'b1;
          if (code_q == OP_LOAD) begin
            result_q   <= imm_q;
            rf_q[rd_q] <= imm_q;
          end else begin
            result_q   <= res_q;
            flag_eq_q  <= eq_q;
            flag_ovf_q <= ovf_q;
            if (code_q != OP_CMP) rf_q[rd_q] <= res_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign result   = result_q;
  assign flag_eq  = flag_eq_q;
  assign flag_ovf = flag_ovf_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: command sequences with hand-computed
// results, flags, register contents, latency and reset behaviour.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_code = '0, op_rd = '0, op_ra = '0, op_rb = '0;
  logic [3:0] op_imm = '0;
  logic       done;
  logic [3:0] result;
  logic       flag_eq, flag_ovf;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.WIDTH(4), .NREG(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .op_rd    (op_rd),
    .op_ra    (op_ra),
    .op_rb    (op_rb),
    .op_imm   (op_imm),
    .done     (done),
    .result   (result),
    .flag_eq  (flag_eq),
    .flag_ovf (flag_ovf),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic peek(input logic [1:0] a, output logic [3:0] d);
    dbg_addr = a;
    #1 d = dbg_data;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one command; returns the number of edges after the accept edge
  // at which done was first seen (-1 if never within the bound).
  task automatic do_cmd(input logic [1:0] code, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb,
                        input logic [3:0] imm, output int lat);
    @(negedge clk);
    op_code = code; op_rd = rd; op_ra = ra; op_rb = rb; op_imm = imm;
    op_valid = 1'b1;
    for (int k = 0; k < 8 && !op_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 op_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] d;
    #1 rst_n = 1'b0;
    #2;
    vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", op_ready); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== 4'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
    vectors++; if ({flag_eq, flag_ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {flag_eq, flag_ovf}); end
    for (int r = 0; r < 4; r++) begin
      peek(2'(r), d);
      vectors++; if (d !== 4'h0) begin miscompares++; $display("FAIL reset_reg%0d: got %h expected 0", r, d); end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    logic [3:0] d;
    do_cmd(2'b00, 2'd0, 2'd0, 2'd0, 4'hF, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL load_latency: got %0d expected 3", lat); end
    vectors++; if (result !== 4'hF) begin miscompares++; $display("FAIL load_result: got %h expected F", result); end
    do_cmd(2'b00, 2'd1, 2'd0, 2'd0, 4'hB, lat);
    do_cmd(2'b01, 2'd2, 2'd0, 2'd1, 4'h0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL add_latency: got %0d expected 3", lat); end
    vectors++; if (result !== 4'hA) begin miscompares++; $display("FAIL add_result: got %h expected A", result); end
    vectors++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL add_ovf: got %b expected 0", flag_ovf); end
    vectors++; if (flag_eq !== 1'b0) begin miscompares++; $display("FAIL add_eq: got %b expected 0", flag_eq); end
    peek(2'd2, d);
    vectors++; if (d !== 4'hA) begin miscompares++; $display("FAIL add_r2: got %h expected A", d); end
    @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_nand_alias();
    int lat;
    logic [3:0] d;
    do_cmd(2'b00, 2'd3, 2'd0, 2'd0, 4'hE, lat);
    do_cmd(2'b10, 2'd3, 2'd3, 2'd3, 4'h0, lat);
    vectors++; if (result !== 4'h1) begin miscompares++; $display("FAIL nand_result: got %h expected 1", result); end
    vectors++; if (flag_eq !== 1'b1) begin miscompares++; $display("FAIL nand_eq: got %b expected 1", flag_eq); end
    vectors++; if (flag_ovf !== 1'b0) begin miscompares++; $display("FAIL nand_ovf: got %b expected 0", flag_ovf); end
    peek(2'd3, d);
    vectors++; if (d !== 4'h1) begin miscompares++; $display("FAIL nand_r3: got %h expected 1", d); end
  endtask

  task automatic test_ovf_sticky();
    int lat;
    do_cmd(2'b00, 2'd0, 2'd0, 2'd0, 4'h8, lat);
    do_cmd(2'b00, 2'd1, 2'd0, 2'd0, 4'hD, lat);
    do_cmd(2'b01, 2'd2, 2'd0, 2'd1, 4'h0, lat);
    vectors++; if (result !== 4'h5) begin miscompares++; $display("FAIL ovf_result: got %h expected 5", result); end
    vectors++; if (flag_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b expected 1", flag_ovf); end
    vectors++; if (flag_eq !== 1'b0) begin miscompares++; $display("FAIL ovf_eq: got %b expected 0", flag_eq); end
    do_cmd(2'b00, 2'd3, 2'd0, 2'd0, 4'h7, lat);
    vectors++; if (result !== 4'h7) begin miscompares++; $display("FAIL sticky_result: got %h expected 7", result); end
    vectors++; if (flag_ovf !== 1'b1) begin miscompares++; $display("FAIL sticky_ovf: got %b expected 1", flag_ovf); end
  endtask

  task automatic test_cmp();
    int lat;
    logic [3:0] d;
    logic [3:0] exp_r [4];
    exp_r[0] = 4'h5; exp_r[1] = 4'h5; exp_r[2] = 4'h5; exp_r[3] = 4'h7;
    do_cmd(2'b00, 2'd0, 2'd0, 2'd0, 4'h5, lat);
    do_cmd(2'b00, 2'd1, 2'd0, 2'd0, 4'h5, lat);
    do_cmd(2'b11, 2'd2, 2'd0, 2'd1, 4'h0, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL cmp_latency: got %0d expected 3", lat); end
    vectors++; if (result !== 4'hA) begin miscompares++; $display("FAIL cmp_result: got %h expected A", result); end
    vectors++; if (flag_eq !== 1'b1) begin miscompares++; $display("FAIL cmp_eq: got %b expected 1", flag_eq); end
    vectors++; if (flag_ovf !== 1'b1) begin miscompares++; $display("FAIL cmp_ovf: got %b expected 1", flag_ovf); end
    for (int r = 0; r < 4; r++) begin
      peek(2'(r), d);
      vectors++; if (d !== exp_r[r]) begin miscompares++; $display("FAIL cmp_reg%0d: got %h expected %h", r, d, exp_r[r]); end
    end
  endtask

  // Fields change every cycle with op_valid held high; only the values
  // present in IDLE (i = 0, 4, 8) are taken: r0=1, r2=5, then r0=9.
  task automatic test_back_to_back();
    logic [3:0] d;
    logic [3:0] exp_r [4];
    exp_r[0] = 4'h9; exp_r[1] = 4'h0; exp_r[2] = 4'h5; exp_r[3] = 4'h0;
    apply_reset();
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      vectors++; if (op_ready !== (i % 4 == 0)) begin miscompares++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, op_ready, (i % 4 == 0)); end
      vectors++; if (done !== (i % 4 == 0 && i != 0)) begin miscompares++; $display("FAIL b2b_done[%0d]: got %b expected %b", i, done, (i % 4 == 0 && i != 0)); end
      if (i < 12) begin
        op_valid = 1'b1;
        op_code  = 2'b00;
        op_rd    = 2'((i >> 1) & 3);
        op_imm   = 4'(i + 1);
      end else begin
        op_valid = 1'b0;
        vectors++; if (result !== 4'h9) begin miscompares++; $display("FAIL b2b_result: got %h expected 9", result); end
      end
    end
    for (int r = 0; r < 4; r++) begin
      peek(2'(r), d);
      vectors++; if (d !== exp_r[r]) begin miscompares++; $display("FAIL b2b_reg%0d: got %h expected %h", r, d, exp_r[r]); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen_done;
    logic [3:0] d;
    apply_reset();
    do_cmd(2'b00, 2'd0, 2'd0, 2'd0, 4'h5, lat);
    do_cmd(2'b00, 2'd1, 2'd0, 2'd0, 4'h5, lat);
    do_cmd(2'b11, 2'd3, 2'd0, 2'd1, 4'h0, lat);
    vectors++; if ({flag_eq, flag_ovf} !== 2'b11) begin miscompares++; $display("FAIL pre_abort_flags: got %b expected 11", {flag_eq, flag_ovf}); end
    @(negedge clk);
    op_code = 2'b01; op_rd = 2'd2; op_ra = 2'd0; op_rb = 2'd1;
    op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL abort_async_ready: got %b expected 1", op_ready); end
    vectors++; if ({flag_eq, flag_ovf} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got %b expected 00", {flag_eq, flag_ovf}); end
    vectors++; if (result !== 4'h0) begin miscompares++; $display("FAIL abort_result: got %h expected 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        vectors++; if (op_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready_first_clk: got %b expected 1", op_ready); end
      end
      if (done) seen_done++;
    end
    vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses expected 0", seen_done); end
    peek(2'd2, d);
    vectors++; if (d !== 4'h0) begin miscompares++; $display("FAIL abort_r2: got %h expected 0", d); end
    peek(2'd0, d);
    vectors++; if (d !== 4'h0) begin miscompares++; $display("FAIL abort_r0: got %h expected 0", d); end
    vectors++; if ({flag_eq, flag_ovf} !== 2'b00) begin miscompares++; $display("FAIL abort_flags_after: got %b expected 00", {flag_eq, flag_ovf}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_nand_alias();
    test_ovf_sticky();
    test_cmp();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
